// File: rtl/mcu_link_master_if.sv
`default_nettype none
// ============================================================================
// Module : mcu_link_master_if
// Brief  : Word-in handshake, MCU REQ/ACK and SPI-style serial lines.
// Rev    : 1.0
// ============================================================================
interface mcu_link_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  MCU_REQ;
  logic                  MCU_ACK;
  logic                  MCU_SPI_SCLK;
  logic                  MCU_SPI_CS;
  logic                  MCU_SPI_MOSI;

  modport master (
    input  in_data, in_valid, MCU_ACK,
    output in_ready, busy, done, err,
           MCU_REQ, MCU_SPI_SCLK, MCU_SPI_CS, MCU_SPI_MOSI
  );

  modport slave (
    output in_data, in_valid, MCU_ACK,
    input  in_ready, busy, done, err,
           MCU_REQ, MCU_SPI_SCLK, MCU_SPI_CS, MCU_SPI_MOSI
  );
endinterface
`default_nettype wire

// File: rtl/mcu_link_master.sv
`default_nettype none
// ============================================================================
// Module : mcu_link_master
// Brief  : REQ/ACK initiator with timeout and MSB-first mode-0 serialiser.
// Rev    : 1.0
// ============================================================================
module mcu_link_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int TIMEOUT    = 1023
) (
  input  wire logic               SYS_CLK,
  input  wire logic               SYS_RSTn,
  mcu_link_master_if.master       link
);

  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int BW  = $clog2(DATA_WIDTH + 1);
  localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ_WAIT = 2'd1,
    S_SHIFT    = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  ack_meta_q;
  logic                  ack_s_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [TW-1:0]         tmo_q;
  logic [BW-1:0]         bit_q;
  logic [DVW-1:0]        div_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  req_q;
  logic                  sclk_q;
  logic                  cs_q;
  logic                  mosi_q;

  logic [TW-1:0]         tmo_d;
  logic [BW-1:0]         bit_d;
  logic [DVW-1:0]        div_d;

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    bit_d = bit_q + 1'b1;
    div_d = div_q + 1'b1;
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      state_q    <= S_IDLE;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      shreg_q    <= '0;
      tmo_q      <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      ack_meta_q <= link.MCU_ACK;
      ack_s_q    <= ack_meta_q;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (link.in_valid && in_ready_q) begin
            shreg_q    <= link.in_data;
            tmo_q      <= '0;
            req_q      <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_REQ_WAIT;
          end
        end

        // A grant seen on the same cycle as the last timeout count still wins.
        S_REQ_WAIT: begin
          if (ack_s_q) begin
            cs_q    <= 1'b0;
            mosi_q  <= shreg_q[DATA_WIDTH-1];
            sclk_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= S_SHIFT;
          end else if (tmo_q == TMO_LAST) begin
            req_q      <= 1'b0;
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end

        S_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (bit_q == BIT_LAST) begin
              sclk_q  <= 1'b0;
              cs_q    <= 1'b1;
              req_q   <= 1'b0;
              mosi_q  <= 1'b0;
              tmo_q   <= '0;
              state_q <= S_RELEASE;
            end else begin
              sclk_q  <= 1'b0;
              bit_q   <= bit_d;
              shreg_q <= {shreg_q[DATA_WIDTH-2:0], 1'b0};
              mosi_q  <= shreg_q[DATA_WIDTH-2];
            end
          end else begin
            div_q <= div_d;
          end
        end

        S_RELEASE: begin
          if (!ack_s_q) begin
            done_q     <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign link.in_ready     = in_ready_q;
  assign link.busy         = busy_q;
  assign link.done         = done_q;
  assign link.err          = err_q;
  assign link.MCU_REQ      = req_q;
  assign link.MCU_SPI_SCLK = sclk_q;
  assign link.MCU_SPI_CS   = cs_q;
  assign link.MCU_SPI_MOSI = mosi_q;

endmodule
`default_nettype wire

// File: doc/mcu_link_master.md
Name: mcu_link_master

Overview:
- Initiator side of the MCU request/acknowledge link. Drives MCU_REQ, samples MCU_ACK, and shifts one data word out on an SPI-style serial line (SCLK/CS/MOSI) once ACK is granted.
- Used on the companion/test FPGA or bench harness to exercise the responder built into the Tang Nano top level, and to push bytes into it.
- Four-phase handshake with timeout, MSB-first mode-0 serialiser, single clock domain.

Parameters:
- DATA_WIDTH, 8, bits per transferred word (2..32).
- CLK_DIV, 4, system clocks per SCLK half-period (>=1).
- TIMEOUT, 1023, maximum system clocks to wait for an ACK edge before aborting (>=4).

Ports:
- SYS_CLK  input  1  system clock; all logic on its rising edge.
- SYS_RSTn  input  1  asynchronous, active-low reset.
- in_data  input  DATA_WIDTH  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high only in IDLE.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a transfer completes normally.
- err  output  1  one-cycle pulse when a transfer is aborted on timeout.
- MCU_REQ  output  1  request to responder.
- MCU_ACK  input  1  acknowledge from responder; asynchronous, 2-flop synchronised internally (ack_s).
- MCU_SPI_SCLK  output  1  serial clock, idle low.
- MCU_SPI_CS  output  1  chip select, active low, idle high.
- MCU_SPI_MOSI  output  1  serial data, MSB first.

Behaviour:
- Reset (asynchronous on SYS_RSTn low, any state, including mid-transfer):
  - MCU_REQ=0, MCU_SPI_SCLK=0, MCU_SPI_CS=1, MCU_SPI_MOSI=0.
  - in_ready=1, busy=0, done=0, err=0.
  - Both synchroniser flops and all counters cleared; state=IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: latch in_data into the shift register, clear the timeout counter, go to REQ_WAIT.
  - MCU_REQ=1 from the next cycle.
- REQ_WAIT:
  - MCU_REQ=1; the timeout counter increments each cycle.
  - When ack_s=1: go to SHIFT. CS=0, MOSI=shreg[MSB], SCLK=0, clear the divider counter.
  - Else, when the timeout counter reaches TIMEOUT: MCU_REQ=0, pulse err, go to IDLE.
  - If ack_s and the timeout occur in the same cycle, ack wins.
- SHIFT:
  - Each bit lasts 2*CLK_DIV cycles: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MOSI changes only on the falling-edge cycle (SCLK high->low); the responder samples on the rising edge.
  - After the DATA_WIDTH-th high phase: SCLK=0, CS=1, MCU_REQ=0, go to RELEASE, clear the timeout counter.
  - SHIFT lasts exactly DATA_WIDTH*2*CLK_DIV cycles.
  - MCU_ACK is ignored during SHIFT; the responder may drop it early without effect.
- RELEASE:
  - Wait for ack_s=0. Then pulse done, go to IDLE (in_ready=1 the same cycle as done).
  - On timeout: pulse err (no done), go to IDLE.
- Rules:
  - done and err are mutually exclusive and never both high.
  - in_valid while busy is ignored; the word is not consumed.
  - The bit counter is ceil(log2(DATA_WIDTH+1)) bits; the divider counter counts 0..CLK_DIV-1 and wraps.
  - CS is never low while MCU_REQ is low, except during zero cycles.
  - Back-to-back words give at least one IDLE cycle (REQ low) between transfers.

Test Plan:
- Reset mid-SHIFT:
  - Stimulus: assert SYS_RSTn=0 asynchronously after 3 bits.
  - Required: outputs immediately at their reset values; no done or err pulse.
- Nominal transfer (DATA_WIDTH=8, CLK_DIV=4):
  - Stimulus: send 0xA5; responder model raises ACK 5 cycles after REQ and drops it 3 cycles after REQ falls.
  - Required: MOSI bit sequence 1,0,1,0,0,1,0,1 sampled on SCLK rising edges; SCLK period 8 cycles; CS low for exactly 64 cycles; one done pulse; no err.
- Request timeout:
  - Stimulus: TIMEOUT=16, ACK held at 0.
  - Required: MCU_REQ high ~16 cycles then low; err pulses once; CS never asserted; in_ready returns to 1.
- Release timeout:
  - Stimulus: ACK stuck at 1 after the grant.
  - Required: after the shift, err pulses TIMEOUT cycles later; no done.
- Back-to-back words:
  - Stimulus: in_valid held high with 0x00 then 0xFF.
  - Required: two complete transfers with MOSI all 0s then all 1s; in_ready low throughout each transfer; REQ low for at least 1 cycle between them; two done pulses.
- ACK glitch and minimum divider:
  - Stimulus: CLK_DIV=1, single-cycle ACK pulse in REQ_WAIT, then ACK drops during SHIFT.
  - Required: the shift still completes (16 cycles for 8 bits); done pulses once ack_s=0 in RELEASE.
